// File: rtl/cpu_prog_ram.sv
// Program RAM for a small CPU: a byte-stream loader fills the storage,
// and a single-cycle-latency fetch port reads it back while the loader is idle.
`ifndef NOP
`define NOP 4'h0
`endif

module cpu_prog_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = {`NOP, 12'b0}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid,
    input  logic                  load_start,
    input  logic [7:0]            load_byte,
    input  logic                  load_byte_valid,
    output logic                  load_busy,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   prog_len
);

    localparam int unsigned BPW    = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDR_WIDTH:0]  DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [BIDX_W-1:0]    LAST_IDX = BIDX_W'(BPW - 1);

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        DATA,
        DONE
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH:0]     prog_len_q;
    logic [ADDR_WIDTH:0]     word_cnt_q;
    logic [BIDX_W-1:0]       byte_idx_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   fetch_data_q;
    logic                    fetch_valid_q;
    logic                    load_busy_q;
    logic                    load_done_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [DATA_WIDTH-1:0]   word_d;
    logic [ADDR_WIDTH:0]     len_d;
    logic [ADDR_WIDTH:0]     prog_len_inc;
    logic                    word_done;
    logic                    fetch_ok;
    logic                    addr_hit;

    always_comb begin
        word_d       = (shift_q << 8) | DATA_WIDTH'(load_byte);
        len_d        = ({24'b0, load_byte} >= DEPTH) ? DEPTH_L : (ADDR_WIDTH + 1)'(load_byte);
        prog_len_inc = prog_len_q + 1'b1;
        word_done    = (state_q == DATA) && load_byte_valid && (byte_idx_q == LAST_IDX);
        fetch_ok     = fetch_en && !load_busy_q;
        addr_hit     = ({1'b0, fetch_addr} < prog_len_q);
    end

    // Storage is deliberately left unreset; prog_len gates every read.
    always_ff @(posedge clk) begin
        if (word_done) begin
            mem[prog_len_q[IDX_W-1:0]] <= word_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            prog_len_q    <= '0;
            word_cnt_q    <= '0;
            byte_idx_q    <= '0;
            shift_q       <= '0;
            fetch_data_q  <= NOP_WORD;
            fetch_valid_q <= 1'b0;
            load_busy_q   <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_q     <= LEN;
                        prog_len_q  <= '0;
                        byte_idx_q  <= '0;
                        shift_q     <= '0;
                        load_busy_q <= 1'b1;
                    end
                end
                LEN: begin
                    if (load_byte_valid) begin
                        word_cnt_q <= len_d;
                        if (len_d == '0) begin
                            state_q     <= DONE;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_done) begin
                        prog_len_q <= prog_len_inc;
                        byte_idx_q <= '0;
                        shift_q    <= '0;
                        if (prog_len_inc == word_cnt_q) begin
                            state_q     <= DONE;
                            load_done_q <= 1'b1;
                        end
                    end else if (load_byte_valid) begin
                        byte_idx_q <= byte_idx_q + 1'b1;
                        shift_q    <= word_d;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    load_busy_q <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    load_busy_q <= 1'b0;
                end
            endcase

            // A fetch coinciding with load_start still sees the old program and length.
            if (fetch_ok) begin
                fetch_valid_q <= 1'b1;
                fetch_data_q  <= addr_hit ? mem[fetch_addr[IDX_W-1:0]] : NOP_WORD;
            end else begin
                fetch_valid_q <= 1'b0;
                if (state_q == IDLE && load_start) begin
                    fetch_data_q <= NOP_WORD;
                end
            end
        end
    end

    assign fetch_data  = fetch_data_q;
    assign fetch_valid = fetch_valid_q;
    assign load_busy   = load_busy_q;
    assign load_done   = load_done_q;
    assign prog_len    = prog_len_q;

endmodule

// File: tb/tb_cpu_prog_ram.sv
// Directed self-checking bench for cpu_prog_ram: reset, fetch, loader and
// load/fetch interaction scenarios with hand-computed expectations.
module tb_cpu_prog_ram;

    localparam logic [15:0] NOP = 16'hF000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic [7:0]  fetch_addr = '0;
    logic [15:0] fetch_data;
    logic        fetch_valid;
    logic        load_start = 1'b0;
    logic [7:0]  load_byte = '0;
    logic        load_byte_valid = 1'b0;
    logic        load_busy;
    logic        load_done;
    logic [8:0]  prog_len;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    cpu_prog_ram #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8),
        .DEPTH(256),
        .NOP_WORD(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fetch_en(fetch_en),
        .fetch_addr(fetch_addr),
        .fetch_data(fetch_data),
        .fetch_valid(fetch_valid),
        .load_start(load_start),
        .load_byte(load_byte),
        .load_byte_valid(load_byte_valid),
        .load_busy(load_busy),
        .load_done(load_done),
        .prog_len(prog_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_byte       = b;
        load_byte_valid = 1'b1;
        tick();
        load_byte_valid = 1'b0;
    endtask

    task automatic do_fetch(input logic [7:0] a);
        fetch_en   = 1'b1;
        fetch_addr = a;
        tick();
        fetch_en   = 1'b0;
    endtask

    task automatic load_std();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send_byte(8'd3);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h9A); send_byte(8'hBC);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL reset_prog_len: got %0d want 0", prog_len); end
        checks++; if (fetch_data !== NOP) begin errors++; $display("FAIL reset_fetch_data: got %h want %h", fetch_data, NOP); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid: got %b want 0", fetch_valid); end
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL reset_load_busy: got %b want 0", load_busy); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b want 0", load_done); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch_after_reset();
        logic [7:0] addrs [3] = '{8'd0, 8'd5, 8'd255};
        for (int i = 0; i < 3; i++) begin
            do_fetch(addrs[i]);
            checks++; if (fetch_data !== NOP) begin errors++; $display("FAIL empty_fetch_data[%0d]: got %h want %h", addrs[i], fetch_data, NOP); end
            checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL empty_fetch_valid[%0d]: got %b want 1", addrs[i], fetch_valid); end
        end
        tick();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL idle_fetch_valid: got %b want 0", fetch_valid); end
    endtask

    task automatic test_load_basic();
        logic [15:0] exp [4] = '{16'h1234, 16'h5678, 16'h9ABC, NOP};
        logic [7:0]  bytes [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        done_cnt = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_len: got %b want 1", load_busy); end
        checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL basic_prog_len_start: got %0d want 0", prog_len); end
        send_byte(8'd3);
        for (int i = 0; i < 6; i++) send_byte(bytes[i]);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL basic_load_done: got %b want 1", load_done); end
        checks++; if (prog_len !== 9'd3) begin errors++; $display("FAIL basic_prog_len: got %0d want 3", prog_len); end
        tick();
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", load_busy); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
        for (int a = 0; a < 4; a++) begin
            do_fetch(8'(a));
            checks++; if (fetch_data !== exp[a] || fetch_valid !== 1'b1) begin
                errors++; $display("FAIL basic_fetch[%0d]: got %h/%b want %h/1", a, fetch_data, fetch_valid, exp[a]);
            end
        end
    endtask

    task automatic test_empty_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send_byte(8'd0);
        checks++; if (load_done !== 1'b1 || load_busy !== 1'b1) begin
            errors++; $display("FAIL empty_done: got done=%b busy=%b want 1/1", load_done, load_busy);
        end
        checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL empty_prog_len: got %0d want 0", prog_len); end
        tick();
        checks++; if (load_busy !== 1'b0 || load_done !== 1'b0) begin
            errors++; $display("FAIL empty_idle: got done=%b busy=%b want 0/0", load_done, load_busy);
        end
        do_fetch(8'd0);
        checks++; if (fetch_data !== NOP) begin errors++; $display("FAIL empty_fetch0: got %h want %h", fetch_data, NOP); end
    endtask

    task automatic test_reset_mid_load();
        load_std();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send_byte(8'd4);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        rst = 1'b1;
        #2;
        checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL abort_prog_len: got %0d want 0", prog_len); end
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", load_busy); end
        rst = 1'b0;
        tick();
        for (int a = 0; a < 2; a++) begin
            do_fetch(8'(a));
            checks++; if (fetch_data !== NOP || fetch_valid !== 1'b1) begin
                errors++; $display("FAIL abort_fetch[%0d]: got %h/%b want %h/1", a, fetch_data, fetch_valid, NOP);
            end
        end
    endtask

    task automatic test_back_to_back();
        load_std();
        fetch_en   = 1'b1;
        fetch_addr = 8'd1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checks++; if (fetch_data !== 16'h5678 || fetch_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_old_word: got %h/%b want 5678/1", fetch_data, fetch_valid);
        end
        checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", load_busy); end
        tick();
        checks++; if (fetch_valid !== 1'b0 || fetch_data !== 16'h5678) begin
            errors++; $display("FAIL b2b_blocked_hold: got %h/%b want 5678/0", fetch_data, fetch_valid);
        end
        send_byte(8'd2);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        checks++; if (load_done !== 1'b1 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_done: got done=%b valid=%b want 1/0", load_done, fetch_valid);
        end
        tick();
        checks++; if (load_busy !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_after_done: got busy=%b valid=%b want 0/0", load_busy, fetch_valid);
        end
        tick();
        checks++; if (fetch_data !== 16'hCCDD || fetch_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_resume: got %h/%b want ccdd/1", fetch_data, fetch_valid);
        end
        fetch_en = 1'b0;
        checks++; if (prog_len !== 9'd2) begin errors++; $display("FAIL b2b_prog_len: got %0d want 2", prog_len); end
    endtask

    task automatic test_gapped_load();
        logic [15:0] exp [3] = '{16'h1122, 16'h3344, NOP};
        do_fetch(8'd0);
        checks++; if (fetch_data !== 16'hAABB) begin errors++; $display("FAIL gap_pre_fetch: got %h want aabb", fetch_data); end
        send_byte(8'h55);
        checks++; if (load_busy !== 1'b0 || prog_len !== 9'd2) begin
            errors++; $display("FAIL gap_idle_byte: got busy=%b len=%0d want 0/2", load_busy, prog_len);
        end
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checks++; if (fetch_data !== NOP || fetch_valid !== 1'b0 || prog_len !== 9'd0) begin
            errors++; $display("FAIL gap_start: got %h/%b len=%0d want %h/0 len=0", fetch_data, fetch_valid, prog_len, NOP);
        end
        tick();
        send_byte(8'd2);
        tick();
        send_byte(8'h11);
        tick(); tick();
        send_byte(8'h22);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checks++; if (load_busy !== 1'b1 || prog_len !== 9'd1) begin
            errors++; $display("FAIL gap_restart_ignored: got busy=%b len=%0d want 1/1", load_busy, prog_len);
        end
        send_byte(8'h33);
        tick();
        send_byte(8'h44);
        checks++; if (load_done !== 1'b1 || prog_len !== 9'd2) begin
            errors++; $display("FAIL gap_done: got done=%b len=%0d want 1/2", load_done, prog_len);
        end
        send_byte(8'h77);
        checks++; if (load_busy !== 1'b0 || prog_len !== 9'd2) begin
            errors++; $display("FAIL gap_done_byte: got busy=%b len=%0d want 0/2", load_busy, prog_len);
        end
        for (int a = 0; a < 3; a++) begin
            do_fetch(8'(a));
            checks++; if (fetch_data !== exp[a] || fetch_valid !== 1'b1) begin
                errors++; $display("FAIL gap_fetch[%0d]: got %h/%b want %h/1", a, fetch_data, fetch_valid, exp[a]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_after_reset();
        test_load_basic();
        test_empty_load();
        test_reset_mid_load();
        test_back_to_back();
        test_gapped_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_prog_ram.md
CPU_PROG_RAM -- requirements
Module: cpu_prog_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning instruction word width; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning fetch address width.
REQ-003 SHALL have parameter DEPTH, default 256, meaning number of storage words, with DEPTH <= 2^ADDR_WIDTH.
REQ-004 SHALL have parameter NOP_WORD, default {`NOP, 12'b0}, meaning the word returned for any unloaded or out-of-range fetch.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 fetch_en  in  1  fetch request.
REQ-008 fetch_addr  in  ADDR_WIDTH  fetch address.
REQ-009 fetch_data  out  DATA_WIDTH  registered instruction word.
REQ-010 fetch_valid  out  1  fetch_data holds the result of a fetch accepted on the previous cycle.
REQ-011 load_start  in  1  one-cycle pulse that begins a program load.
REQ-012 load_byte  in  8  loader byte stream.
REQ-013 load_byte_valid  in  1  load_byte qualifier, one byte per asserted cycle.
REQ-014 load_busy  out  1  loader active; the CPU halts while it is high.
REQ-015 load_done  out  1  one-cycle pulse when a load completes.
REQ-016 prog_len  out  ADDR_WIDTH+1  number of valid words currently stored.

Function
REQ-017 Loader FSM SHALL have states IDLE, LEN, DATA and DONE.
REQ-018 IDLE->LEN SHALL occur on load_start; prog_len SHALL clear to 0 in the same cycle; load_start outside IDLE SHALL be ignored.
REQ-019 In LEN, the first valid byte SHALL set the word count N = min(byte, DEPTH); N=0 SHALL go directly to DONE, otherwise to DATA.
REQ-020 In DATA, bytes SHALL assemble MSB-first into words of DATA_WIDTH/8 bytes; each completed word SHALL be written at address prog_len, and prog_len SHALL then increment.
REQ-021 After the Nth word is written, the FSM SHALL go to DONE.
REQ-022 DONE SHALL last one cycle with load_done=1, then return to IDLE.
REQ-023 load_busy SHALL be 1 in LEN, DATA and DONE, and 0 in IDLE.
REQ-024 load_byte_valid in IDLE or DONE SHALL be ignored.
REQ-025 A fetch SHALL be accepted when fetch_en=1 and load_busy=0; fetch_data and fetch_valid=1 SHALL appear on the next clock edge (latency 1).
REQ-026 An accepted fetch with fetch_addr >= prog_len SHALL return NOP_WORD; storage SHALL never be read beyond prog_len.
REQ-027 With fetch_en=0 or load_busy=1, fetch_valid SHALL be 0 on the next edge, and fetch_data SHALL hold its value, except that it SHALL read NOP_WORD on the first cycle of a load.
REQ-028 A fetch in the same cycle as load_start SHALL be accepted and SHALL use the old contents; load_busy takes effect on the next cycle.
REQ-029 Reading a word in the same cycle it is written is impossible, because fetch is blocked while load_busy=1.

Reset
REQ-030 While rst is asserted: FSM=IDLE; prog_len=0; fetch_data=NOP_WORD; fetch_valid=0; load_busy=0; load_done=0; partial-word and count registers cleared.
REQ-031 Storage contents SHALL NOT be reset, but are unreachable because prog_len=0.
REQ-032 rst asserted mid-load SHALL abort the load; every fetch after rst deasserts returns NOP_WORD until a new load completes.

Verification
REQ-033 After reset, fetch addresses 0, 5 and 255 -> NOP_WORD with fetch_valid=1 one cycle after each request.
REQ-034 Load a length byte of 3 followed by bytes 12 34 56 78 9A BC -> load_done pulses once, prog_len=3; fetch addresses 0, 1, 2, 3 -> 16'h1234, 16'h5678, 16'h9ABC, NOP_WORD.
REQ-035 Load a length byte of 0 -> DONE directly, prog_len=0; fetch address 0 -> NOP_WORD.
REQ-036 Load a length byte of 4, then assert rst after 3 data bytes -> prog_len=0, load_busy=0; fetch address 0 -> NOP_WORD.
REQ-037 Hold fetch_en=1 throughout a load, with load_start coinciding with a fetch -> that fetch returns the old word; fetch_valid=0 while busy; fetches resume after DONE.
REQ-038 Gapped load_byte_valid, plus a second load_start while busy -> identical stored data; the second load_start is ignored.
